tmds_serializer_n: RTL
======================

Name: tmds_serializer_n

Overview:
- Parametrised pure-RTL successor to the two-primitive 10:1 output serializer.
- Converts CHANNELS parallel words of WIDTH bits into CHANNELS single-rate serial bit streams, all running on one bit-rate clock.
- Accepts words through a valid/ready handshake with a one-word holding register per lane group, inserts an idle word on underrun, and counts underruns.
- Sits between the TMDS encoders and the output pads of the video path. It is also used for narrow serial links by changing WIDTH/CHANNELS.

Parameters:
- CHANNELS, 3, number of serial lanes. All lanes advance in lockstep.
- WIDTH, 10, bits per word. Legal range 2..32.
- LSB_FIRST, 1: 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first.
- IDLE_WORD, 10'b1101010100, word sent on every lane when no data is available. WIDTH bits.
- CNT_W, 16, width of the underrun counter.

Ports:
- serial_clk  input  1  bit-rate clock; the single clock of the block.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  start/stop request for serialization.
- s_valid  input  1  input word valid.
- s_ready  output  1  holding register can accept a word.
- s_data  input  CHANNELS*WIDTH  lane k word in bits [k*WIDTH +: WIDTH].
- serial_out  output  CHANNELS  serial bit per lane, registered.
- word_start  output  1  high in the cycle serial_out carries the first bit of a word.
- underrun  output  1  one-cycle pulse when IDLE_WORD is substituted in RUN.
- underrun_cnt  output  CNT_W  saturating count of underrun pulses.
- busy  output  1  high whenever the state is not STOP.

Behaviour:
- Reset (async, reset_n=0):
  - state=STOP; bit_cnt=0; hold_full=0.
  - Shift registers, serial_out, word_start, underrun and underrun_cnt are all 0.
- Holding register:
  - One word for all lanes. Handshake completes when s_valid and s_ready are both high on a clock edge.
  - s_ready = !hold_full || load_now. Word-in and word-out can happen in the same cycle, so an accept on a load cycle leaves the register full.
  - Prefill is allowed in STOP.
- State machine:
  - STOP:
    - serial_out=0, word_start=0, bit_cnt held at 0.
    - When enable=1, go to START.
  - START (1 cycle):
    - load_now=1. The shift register takes the holding word if hold_full=1, otherwise IDLE_WORD. No underrun is flagged in this cycle.
    - Go to RUN with bit_cnt=0.
  - RUN:
    - Each cycle, serial_out presents the next bit and bit_cnt increments.
    - When bit_cnt==WIDTH-1:
      - bit_cnt wraps to 0.
      - If enable=0, go to STOP after the last bit. Words are never truncated.
      - Otherwise load_now=1. The shift register takes the holding word if full; else it takes IDLE_WORD and underrun pulses in that same cycle.
- word_start is high while bit_cnt==0 in RUN.
- Serial latency: the first bit of a word appears on serial_out 2 cycles after enable rises, provided the word was prefilled.
- Steady state: one word is consumed every WIDTH cycles. s_ready rises in the load cycle.
- underrun_cnt:
  - Increments on each underrun pulse and saturates at 2^CNT_W-1.
  - Cleared only by reset.
- enable toggling inside a word has no effect until the word boundary. enable low then high before the boundary continues without a STOP gap.
- reset_n asserted mid-word: outputs go to their reset values immediately. Any held word is discarded.

Optional Feature:
- Macro SER_TRAINING_EN.
- When defined:
  - Adds input train_en (1 bit) and parameter TRAIN_WORD (default 10'b1111100000).
  - In START or RUN, any load with train_en=1 takes TRAIN_WORD on all lanes.
  - During such a load the holding register is untouched, s_ready is forced to 0, and no underrun is counted.
  - Used for receiver word-alignment.
- When not defined:
  - Neither the port nor the parameter exists. Behaviour is exactly as above.

Test Plan:
- Reset: drive reset_n=0 mid-RUN with serial_out toggling -> serial_out=0, busy=0, s_ready=1, underrun_cnt=0 in the same cycle.
- Order: prefill lane0=10'h2AB, enable=1, LSB_FIRST=1 -> word_start 2 cycles later; lane0 emits 1,1,0,1,0,1,0,1,0,1 in that order. With LSB_FIRST=0 the reversed order appears.
- Back-to-back: hold s_valid=1 with an incrementing word per handshake -> one handshake every 10 cycles; no gaps between words; underrun never pulses.
- Underrun: supply one word, then s_valid=0 -> at the next boundary underrun pulses once and IDLE_WORD 10'b1101010100 is emitted. After 3 idle words underrun_cnt=3. With CNT_W=2 the counter saturates at 3.
- Stop: drop enable at bit 4 of a word -> remaining bits 5..9 are emitted, then STOP and serial_out=0. A word accepted meanwhile stays held and is sent first after re-enable.
- Training (SER_TRAINING_EN): with train_en=1 every lane repeats 10'b1111100000, and s_ready=0 on load cycles. Dropping train_en resumes held data at the next boundary with underrun_cnt unchanged.

Source files
------------

// File: rtl/tmds_serializer_n.sv
// tmds_serializer_n: parametrised N-lane word-to-serial converter, one
// bit-rate clock for everything.
//
// Optional build macro: SER_TRAINING_EN adds the train_en input and the
// TRAIN_WORD parameter (alignment pattern forced onto every lane on load).
//
// Ports:
//   serial_clk    bit-rate clock
//   reset_n       async active-low reset
//   enable        start/stop request, sampled only at word boundaries
//   s_valid/s_ready/s_data  word handshake into a one-word holding register,
//                 lane k word in s_data[k*WIDTH +: WIDTH]
//   serial_out    registered serial bit per lane
//   word_start    serial_out carries bit 0 of a word
//   underrun      pulse in the load cycle where IDLE_WORD replaces data (RUN)
//   underrun_cnt  saturating count of underrun pulses
//   busy          state is not STOP
//   train_en      (SER_TRAINING_EN only) loads take TRAIN_WORD

// Per-lane shift register. On load the first bit goes straight to the
// output register and the rest of the word is kept pre-shifted, so the
// next bit always sits at the same end of sr.
module tmds_serializer_n_lane #(
  parameter int WIDTH     = 10,
  parameter int LSB_FIRST = 1
) (
  input  logic             serial_clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] word,
  output logic             ser
);
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] src_nxt;
  logic             src_bit;

  assign src     = load ? word : sr;
  assign src_bit = (LSB_FIRST != 0) ? src[0] : src[WIDTH-1];
  assign src_nxt = (LSB_FIRST != 0) ? (src >> 1) : (src << 1);

  always_ff @(posedge serial_clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      ser <= 1'b0;
    end else if (load || shift) begin
      ser <= src_bit;
      sr  <= src_nxt;
    end else begin
      ser <= 1'b0;
    end
  end
endmodule

module tmds_serializer_n #(
  parameter int               CHANNELS   = 3,
  parameter int               WIDTH      = 10,
  parameter int               LSB_FIRST  = 1,
  parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(10'b1101010100),
`ifdef SER_TRAINING_EN
  parameter logic [WIDTH-1:0] TRAIN_WORD = WIDTH'(10'b1111100000),
`endif
  parameter int               CNT_W      = 16
) (
  input  logic                      serial_clk,
  input  logic                      reset_n,
  input  logic                      enable,
`ifdef SER_TRAINING_EN
  input  logic                      train_en,
`endif
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [CHANNELS*WIDTH-1:0] s_data,
  output logic [CHANNELS-1:0]       serial_out,
  output logic                      word_start,
  output logic                      underrun,
  output logic [CNT_W-1:0]          underrun_cnt,
  output logic                      busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {ST_STOP, ST_START, ST_RUN} state_t;

  state_t                            state, state_n;
  logic [CW-1:0]                     bit_cnt;
  logic                              last_bit;
  logic                              load_now;
  logic                              shift_now;
  logic                              train_load;
  logic                              hold_take;
  logic                              accept;
  logic                              hold_full;
  logic [CHANNELS-1:0][WIDTH-1:0]    hold_data;
  logic [CHANNELS-1:0][WIDTH-1:0]    lane_word;

  assign last_bit = (bit_cnt == CW'(WIDTH-1));

  always_comb begin
    state_n  = state;
    load_now = 1'b0;
    case (state)
      ST_STOP:  if (enable) state_n = ST_START;
      ST_START: begin
        load_now = 1'b1;
        state_n  = ST_RUN;
      end
      ST_RUN: begin
        if (last_bit) begin
          if (enable) load_now = 1'b1;
          else        state_n  = ST_STOP;
        end
      end
      default: state_n = ST_STOP;
    endcase
  end

  always_ff @(posedge serial_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_STOP;
    else          state <= state_n;
  end

  // bit_cnt tracks which bit serial_out will carry after this edge.
  always_ff @(posedge serial_clk or negedge reset_n) begin
    if (!reset_n)               bit_cnt <= '0;
    else if (state == ST_RUN)   bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
    else                        bit_cnt <= '0;
  end

`ifdef SER_TRAINING_EN
  assign train_load = load_now && train_en;
`else
  assign train_load = 1'b0;
`endif

  // A training load leaves the holding register alone and blocks input.
  assign hold_take = load_now && !train_load;
  assign s_ready   = !train_load && (!hold_full || load_now);
  assign accept    = s_valid && s_ready;
  assign underrun  = hold_take && (state == ST_RUN) && !hold_full;

  always_ff @(posedge serial_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      // Word-out and word-in on the same edge leaves the register full.
      if (hold_take)   hold_full <= accept;
      else if (accept) hold_full <= 1'b1;
      if (accept) hold_data <= s_data;
    end
  end

  always_comb begin
    lane_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
`ifdef SER_TRAINING_EN
      if (train_load)     lane_word[k] = TRAIN_WORD;
      else
`endif
      if (hold_full)      lane_word[k] = hold_data[k];
      else                lane_word[k] = IDLE_WORD;
    end
  end

  assign shift_now = (state == ST_RUN) && !last_bit;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    tmds_serializer_n_lane #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_lane (
      .serial_clk (serial_clk),
      .reset_n    (reset_n),
      .load       (load_now),
      .shift      (shift_now),
      .word       (lane_word[k]),
      .ser        (serial_out[k])
    );
  end

  always_ff @(posedge serial_clk or negedge reset_n) begin
    if (!reset_n)
      underrun_cnt <= '0;
    else if (underrun && (underrun_cnt != {CNT_W{1'b1}}))
      underrun_cnt <= underrun_cnt + CNT_W'(1);
  end

  assign word_start = (state == ST_RUN) && (bit_cnt == '0);
  assign busy       = (state != ST_STOP);

endmodule
